// File: rtl/lsu_mem_master.sv
// lsu_mem_master
// ---------------------------------------------------------------------------
// CPU-side load/store initiator for a word-organised data memory with
// combinational read and synchronous (posedge) write. One command is taken
// at a time from the MEM stage.
// - Sub-word stores (sh/sb) run as a read-modify-write.
// - Sub-word loads are extracted and then sign- or zero-extended.
// - Misaligned or out-of-range commands complete with exc=1 and never touch
//   the memory.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   start        command strobe, sampled only while idle
//   op[2:0]      0=lw 1=lh 2=lhu 3=lb 4=lbu 5=sw 6=sh 7=sb
//   addr[31:0]   byte address
//   wdata[31:0]  store data (sh uses [15:0], sb uses [7:0])
//   busy         high whenever a command is in flight (not idle)
//   done         one-cycle completion pulse
//   rdata[31:0]  load result, held until the next successful load
//   exc          error flag, valid with done and held until the next done
//   mem_addr     word-aligned byte address to memory (0 when idle)
//   mem_wd       write word to memory
//   mem_we       memory write enable, one cycle per store
//   mem_rd       combinational read data from memory
// ---------------------------------------------------------------------------
module lsu_mem_master #(
  parameter int MEM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        exc,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  logic [2:0]  op_r;
  logic [1:0]  addr_lo_r;   // byte lane of the latched address
  logic [15:0] wdata_lo_r;  // only the sub-word part is needed after acceptance
  logic        misaligned_s;
  logic        out_of_range_s;
  logic        cmd_err_s;

  // Select the addressed half/byte of a word and extend it as the load demands.
  function automatic logic [31:0] load_extract(input logic [2:0]  f_op,
                                               input logic [31:0] f_word,
                                               input logic [1:0]  f_lane);
    logic [7:0]  f_byte;
    logic [15:0] f_half;
    logic [31:0] f_res;
    case (f_lane)
      2'd0:    f_byte = f_word[7:0];
      2'd1:    f_byte = f_word[15:8];
      2'd2:    f_byte = f_word[23:16];
      2'd3:    f_byte = f_word[31:24];
      default: f_byte = 8'h00;
    endcase
    if (f_lane[1]) begin
      f_half = f_word[31:16];
    end else begin
      f_half = f_word[15:0];
    end
    case (f_op)
      3'd0:    f_res = f_word;
      3'd1:    f_res = {{16{f_half[15]}}, f_half};
      3'd2:    f_res = {16'h0000, f_half};
      3'd3:    f_res = {{24{f_byte[7]}}, f_byte};
      3'd4:    f_res = {24'h000000, f_byte};
      default: f_res = f_word;
    endcase
    return f_res;
  endfunction

  // Replace the addressed half (sh) or byte (sb) of the buffered word.
  function automatic logic [31:0] store_merge(input logic [2:0]  f_op,
                                              input logic [31:0] f_word,
                                              input logic [15:0] f_data,
                                              input logic [1:0]  f_lane);
    logic [31:0] f_res;
    f_res = f_word;
    if (f_op == 3'd6) begin
      if (f_lane[1]) begin
        f_res[31:16] = f_data;
      end else begin
        f_res[15:0] = f_data;
      end
    end else begin
      case (f_lane)
        2'd0:    f_res[7:0]   = f_data[7:0];
        2'd1:    f_res[15:8]  = f_data[7:0];
        2'd2:    f_res[23:16] = f_data[7:0];
        2'd3:    f_res[31:24] = f_data[7:0];
        default: f_res = f_word;
      endcase
    end
    return f_res;
  endfunction

  // Classify the incoming command; it is only acted on at the acceptance edge,
  // so checking the inputs is the same as checking the latched command.
  always_comb begin
    misaligned_s = 1'b0;
    case (op)
      3'd0, 3'd5:       misaligned_s = (addr[1:0] != 2'b00);
      3'd1, 3'd2, 3'd6: misaligned_s = addr[0];
      default:          misaligned_s = 1'b0;
    endcase
    out_of_range_s = ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
    cmd_err_s      = misaligned_s | out_of_range_s;
  end

  // Command sequencer with all outputs registered. For sh/sb, mem_wd doubles
  // as the word buffer: the merged word is formed from mem_rd at the end of
  // READ and held through WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      op_r       <= 3'd0;
      addr_lo_r  <= 2'd0;
      wdata_lo_r <= 16'h0000;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= 32'h0000_0000;
      exc        <= 1'b0;
      mem_addr   <= 32'h0000_0000;
      mem_wd     <= 32'h0000_0000;
      mem_we     <= 1'b0;
    end else begin
      done   <= 1'b0;
      mem_we <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r       <= op;
            addr_lo_r  <= addr[1:0];
            wdata_lo_r <= wdata[15:0];
            busy       <= 1'b1;
            if (cmd_err_s) begin
              state_r <= DONE;
              done    <= 1'b1;
              exc     <= 1'b1;
            end else if (op == 3'd5) begin
              state_r  <= WRITE;
              mem_we   <= 1'b1;
              mem_addr <= {addr[31:2], 2'b00};
              mem_wd   <= wdata;
            end else begin
              state_r  <= READ;
              mem_addr <= {addr[31:2], 2'b00};
            end
          end
        end
        READ: begin
          if (op_r >= 3'd6) begin
            state_r <= WRITE;
            mem_we  <= 1'b1;
            mem_wd  <= store_merge(op_r, mem_rd, wdata_lo_r, addr_lo_r);
          end else begin
            state_r  <= DONE;
            done     <= 1'b1;
            exc      <= 1'b0;
            rdata    <= load_extract(op_r, mem_rd, addr_lo_r);
            mem_addr <= 32'h0000_0000;
          end
        end
        WRITE: begin
          state_r  <= DONE;
          done     <= 1'b1;
          exc      <= 1'b0;
          mem_addr <= 32'h0000_0000;
          mem_wd   <= 32'h0000_0000;
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        exc;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  int checks = 0;
  int errors = 0;

  // memory attached to the DUT, plus a backdoor write port for preloading
  logic [31:0] mem [0:3071];
  logic        bd_en = 1'b0;
  logic [11:0] bd_idx = 12'd0;
  logic [31:0] bd_val = 32'h0;
  int          we_cnt = 0;
  logic [31:0] last_wa = 32'h0;
  logic [31:0] last_wd = 32'h0;

  // reference state
  logic [31:0] ref_mem [0:3071];
  logic [31:0] ref_rdata;
  logic        ref_exc;

  always #5 clk = ~clk;

  assign mem_rd = (mem_addr[31:2] < 30'd3072) ? mem[mem_addr[13:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_addr[31:2] < 30'd3072) mem[mem_addr[13:2]] <= mem_wd;
      we_cnt  <= we_cnt + 1;
      last_wa <= mem_addr;
      last_wd <= mem_wd;
    end else if (bd_en) begin
      mem[bd_idx] <= bd_val;
    end
  end

  lsu_mem_master #(.MEM_WORDS(3072)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .exc(exc),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic bd_write(input int idx, input logic [31:0] v);
    @(negedge clk);
    bd_en  = 1'b1;
    bd_idx = idx[11:0];
    bd_val = v;
    @(posedge clk);
    #1;
    bd_en = 1'b0;
    ref_mem[idx] = v;
  endtask

  function automatic bit is_err(input logic [2:0] o, input logic [31:0] a);
    bit mis;
    mis = ((o == 3'd0 || o == 3'd5) && a[1:0] != 2'b00) ||
          ((o == 3'd1 || o == 3'd2 || o == 3'd6) && a[0]);
    return mis || (a[31:2] >= 30'd3072);
  endfunction

  // Issue one command, follow it to done and compare against the reference.
  // With poke set, a different store is strobed during the second cycle,
  // which the DUT must ignore.
  task automatic run_cmd(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] d, input bit poke);
    bit          err;
    int          exp_lat, lat, we0, idx, sh;
    int          exp_we;
    logic [31:0] w, v, mask;
    err = is_err(o, a);
    idx = int'(a[31:2]);
    exp_lat = err ? 1 : (o >= 3'd6 ? 3 : 2);
    exp_we  = (!err && o >= 3'd5) ? 1 : 0;
    if (!err) begin
      w = ref_mem[idx];
      if (o <= 3'd4) begin
        v = w >> (8 * int'(a[1:0]));
        case (o)
          3'd0: ref_rdata = w;
          3'd1: ref_rdata = {{16{v[15]}}, v[15:0]};
          3'd2: ref_rdata = {16'h0, v[15:0]};
          3'd3: ref_rdata = {{24{v[7]}}, v[7:0]};
          default: ref_rdata = {24'h0, v[7:0]};
        endcase
      end else if (o == 3'd5) begin
        ref_mem[idx] = d;
      end else begin
        sh   = (o == 3'd6) ? 16 * int'(a[1]) : 8 * int'(a[1:0]);
        mask = ((o == 3'd6) ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        ref_mem[idx] = (w & ~mask) | ((d << sh) & mask);
      end
    end
    ref_exc = err;
    we0 = we_cnt;

    @(negedge clk);
    start = 1'b1; op = o; addr = a; wdata = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", {31'h0, busy}, 32'd1);
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (poke && c == 1) begin
        start = 1'b1; op = 3'd5; addr = 32'h40; wdata = 32'h5A5A_5A5A;
      end
      if (poke && c == 2) start = 1'b0;
      if (done) lat = c;
    end
    start = 1'b0;
    check("latency", lat, exp_lat);
    check("exc", {31'h0, exc}, {31'h0, ref_exc});
    check("rdata", rdata, ref_rdata);
    check("we_count", we_cnt - we0, exp_we);
    if (exp_we == 1) begin
      check("write_addr", last_wa, {a[31:2], 2'b00});
      check("mem_word", mem[idx], ref_mem[idx]);
    end
    if (o == 3'd5 && exp_we == 1) check("sw_wd", last_wd, d);
    @(posedge clk);
    #1;
    check("done_pulse", {31'h0, done}, 32'd0);
    check("busy_idle", {31'h0, busy}, 32'd0);
    check("idle_mem_addr", mem_addr, 32'h0);
    if (poke) check("poke_ignored", mem[16], ref_mem[16]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'h0, busy}, 32'd0);
    check({tag, "_done"}, {31'h0, done}, 32'd0);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_exc"}, {31'h0, exc}, 32'd0);
    check({tag, "_we"}, {31'h0, mem_we}, 32'd0);
    check({tag, "_maddr"}, mem_addr, 32'h0);
    check({tag, "_mwd"}, mem_wd, 32'h0);
  endtask

  initial begin
    int w0, any_done;
    logic [2:0]  ro;
    logic [31:0] ra;
    rst = 1'b1; start = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0;
    ref_rdata = 32'h0; ref_exc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    for (int i = 0; i < 64; i++) bd_write(i, $urandom());
    for (int i = 3068; i < 3072; i++) bd_write(i, $urandom());
    bd_write(16, 32'h1234_5678);
    @(negedge clk);
    rst = 1'b0;

    // directed: store, loads, sub-word RMW
    run_cmd(3'd5, 32'h10, 32'hDEAD_BEEF, 1'b0);
    check("sw_word4", mem[4], 32'hDEAD_BEEF);
    bd_write(4, 32'h80FF_7F01);
    run_cmd(3'd3, 32'h13, 32'h0, 1'b0);  check("lb_val", rdata, 32'hFFFF_FF80);
    run_cmd(3'd4, 32'h13, 32'h0, 1'b0);  check("lbu_val", rdata, 32'h0000_0080);
    run_cmd(3'd1, 32'h12, 32'h0, 1'b0);  check("lh_val", rdata, 32'hFFFF_80FF);
    run_cmd(3'd2, 32'h10, 32'h0, 1'b0);  check("lhu_val", rdata, 32'h0000_7F01);
    run_cmd(3'd0, 32'h10, 32'h0, 1'b0);  check("lw_val", rdata, 32'h80FF_7F01);
    bd_write(4, 32'h1122_3344);
    run_cmd(3'd7, 32'h11, 32'h0000_00AB, 1'b0); check("sb_word4", mem[4], 32'h1122_AB44);
    run_cmd(3'd6, 32'h12, 32'h0000_CDEF, 1'b0); check("sh_word4", mem[4], 32'hCDEF_AB44);

    // errors and range boundary
    run_cmd(3'd0, 32'h12, 32'h0, 1'b0);   check("err_rdata_held", rdata, 32'h80FF_7F01);
    run_cmd(3'd5, 32'h3000, 32'h1, 1'b0); check("err_oor_exc", {31'h0, exc}, 32'd1);
    run_cmd(3'd0, 32'h2FFC, 32'h0, 1'b0); check("lastword_exc", {31'h0, exc}, 32'd0);

    // start strobed during READ of an sb is ignored
    run_cmd(3'd7, 32'h22, 32'h0000_0077, 1'b1);

    // reset in the READ cycle of sb at 0x20
    w0 = we_cnt;
    bd_write(8, 32'hCAFE_F00D);
    @(negedge clk);
    start = 1'b1; op = 3'd7; addr = 32'h20; wdata = 32'h0000_00EE;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("midreset");
    any_done = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) any_done = 1;
    end
    check("midreset_no_done", any_done, 0);
    check("midreset_no_we", we_cnt - w0, 0);
    check("midreset_word8", mem[8], 32'hCAFE_F00D);
    ref_rdata = 32'h0; ref_exc = 1'b0;

    // randomized commands
    for (int n = 0; n < 200; n++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       ra = {30'd3072 + 30'($urandom_range(0, 5000)), 2'($urandom_range(0, 3))};
        1:       ra = {30'd3068 + 30'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
        default: ra = {30'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      endcase
      run_cmd(ro, ra, $urandom(), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
